// File: rtl/config_frame_loader.sv
// config_frame_loader: hunts for a sync word, decodes frame headers (index +
// burst count), sequences row selects for each data word and commits each
// completed frame with a one-hot address and a timed LongFrameStrobe.
module config_frame_loader #(
    parameter int          NumberOfRows    = 16,
    parameter int          RowSelectWidth  = 5,
    parameter int          FramesPerColumn = 20,
    parameter int          FrameSelWidth   = 5,
    parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1,
    parameter int          DesyncBit       = 31,
    parameter int          StrobeLength    = 2
) (
    input  logic                       CLK,
    input  logic                       Resetn,
    input  logic [31:0]                WriteData,
    input  logic                       WriteStrobe,
    output logic [FramesPerColumn-1:0] FrameAddressRegister,
    output logic                       LongFrameStrobe,
    output logic [RowSelectWidth-1:0]  RowSelect,
    output logic                       Synced,
    output logic                       Busy,
    output logic                       Error,
    output logic [15:0]                FramesDone
);

    localparam int StrobeCntWidth = $clog2(StrobeLength + 1);
    localparam logic [31:0] FrameLimit = FramesPerColumn;
    localparam logic [FramesPerColumn-1:0] OneHotBase = FramesPerColumn'(1);

    typedef enum logic [1:0] {
        S_UNSYNC,
        S_HEADER,
        S_DATA
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [RowSelectWidth-1:0]   r_row_cnt;
    logic [FrameSelWidth-1:0]    r_cur_frame;
    logic [6:0]                  r_remaining;
    logic [StrobeCntWidth-1:0]   r_strobe_cnt;
    logic [FramesPerColumn-1:0]  r_frame_addr;
    logic                        r_error;
    logic [15:0]                 r_frames_done;

    logic [FrameSelWidth-1:0]    w_hdr_index;
    logic                        w_hdr_bad;
    logic                        w_frame_last;
    logic                        w_load_header;
    logic                        w_commit;
    logic                        w_next_frame;
    logic                        w_row_dec;
    logic                        w_set_error;
    logic                        w_clr_error;

    assign w_hdr_index  = WriteData[FrameSelWidth-1:0];
    assign w_hdr_bad    = 32'(w_hdr_index) >= FrameLimit;
    assign w_frame_last = (32'(r_cur_frame) + 32'd1) >= FrameLimit;

    // Next-state decode and per-word action strobes
    always_comb begin
        w_state_nxt   = r_state;
        w_load_header = 1'b0;
        w_commit      = 1'b0;
        w_next_frame  = 1'b0;
        w_row_dec     = 1'b0;
        w_set_error   = 1'b0;
        w_clr_error   = 1'b0;
        case (r_state)
            S_UNSYNC: begin
                if (WriteStrobe && (WriteData == SyncWord)) begin
                    w_state_nxt = S_HEADER;
                    w_clr_error = 1'b1;
                end
            end
            S_HEADER: begin
                if (WriteStrobe) begin
                    if (WriteData[DesyncBit]) begin
                        w_state_nxt = S_UNSYNC;
                    end else if (w_hdr_bad) begin
                        w_set_error = 1'b1;
                        w_state_nxt = S_UNSYNC;
                    end else begin
                        w_load_header = 1'b1;
                        w_state_nxt   = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (WriteStrobe) begin
                    if (r_row_cnt == RowSelectWidth'(1)) begin
                        w_commit = 1'b1;
                        if (r_remaining == '0) begin
                            w_state_nxt = S_HEADER;
                        end else if (w_frame_last) begin
                            w_set_error = 1'b1;
                            w_state_nxt = S_UNSYNC;
                        end else begin
                            w_next_frame = 1'b1;
                        end
                    end else begin
                        w_row_dec = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_UNSYNC;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_UNSYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Row counter, current frame and remaining burst count
    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            r_row_cnt   <= '0;
            r_cur_frame <= '0;
            r_remaining <= '0;
        end else if (w_load_header) begin
            r_row_cnt   <= RowSelectWidth'(NumberOfRows);
            r_cur_frame <= w_hdr_index;
            r_remaining <= WriteData[30:24];
        end else if (w_next_frame) begin
            r_row_cnt   <= RowSelectWidth'(NumberOfRows);
            r_cur_frame <= r_cur_frame + FrameSelWidth'(1);
            r_remaining <= r_remaining - 7'd1;
        end else if (w_row_dec) begin
            r_row_cnt   <= r_row_cnt - RowSelectWidth'(1);
        end
    end

    // Frame commit: one-hot address and committed-frame count
    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            r_frame_addr  <= '0;
            r_frames_done <= '0;
        end else if (w_commit) begin
            r_frame_addr  <= OneHotBase << r_cur_frame;
            r_frames_done <= r_frames_done + 16'd1;
        end
    end

    // Strobe timer: a commit (re)loads it, otherwise it counts down to zero
    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            r_strobe_cnt <= '0;
        end else if (w_commit) begin
            r_strobe_cnt <= StrobeCntWidth'(StrobeLength);
        end else if (r_strobe_cnt != '0) begin
            r_strobe_cnt <= r_strobe_cnt - StrobeCntWidth'(1);
        end
    end

    // Sticky error: set by bad header or burst overrun, cleared by SyncWord
    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            r_error <= 1'b0;
        end else if (w_set_error) begin
            r_error <= 1'b1;
        end else if (w_clr_error) begin
            r_error <= 1'b0;
        end
    end

    assign RowSelect            = (r_state == S_DATA && WriteStrobe) ? r_row_cnt : '1;
    assign FrameAddressRegister = r_frame_addr;
    assign LongFrameStrobe      = (r_strobe_cnt != '0);
    assign Synced               = (r_state != S_UNSYNC);
    assign Busy                 = (r_state == S_DATA);
    assign Error                = r_error;
    assign FramesDone           = r_frames_done;

endmodule

// File: tb/tb_config_frame_loader.sv
// Testbench for config_frame_loader: directed scenarios plus a randomized word
// stream, all checked against a word-level behavioural model.
module tb_config_frame_loader;

    localparam int          NR   = 16;
    localparam int          FPC  = 20;
    localparam int          SL   = 2;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    localparam int P_HUNT = 0;
    localparam int P_HDR  = 1;
    localparam int P_DATA = 2;

    logic           CLK = 1'b0;
    logic           Resetn = 1'b0;
    logic [31:0]    WriteData = '0;
    logic           WriteStrobe = 1'b0;
    logic [FPC-1:0] FrameAddressRegister;
    logic           LongFrameStrobe;
    logic [4:0]     RowSelect;
    logic           Synced;
    logic           Busy;
    logic           Error;
    logic [15:0]    FramesDone;

    config_frame_loader #(
        .NumberOfRows   (NR),
        .RowSelectWidth (5),
        .FramesPerColumn(FPC),
        .FrameSelWidth  (5),
        .SyncWord       (SYNC),
        .DesyncBit      (31),
        .StrobeLength   (SL)
    ) dut (
        .CLK                 (CLK),
        .Resetn              (Resetn),
        .WriteData           (WriteData),
        .WriteStrobe         (WriteStrobe),
        .FrameAddressRegister(FrameAddressRegister),
        .LongFrameStrobe     (LongFrameStrobe),
        .RowSelect           (RowSelect),
        .Synced              (Synced),
        .Busy                (Busy),
        .Error               (Error),
        .FramesDone          (FramesDone)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Behavioural model: which kind of word is expected next, how many rows
    // of the current frame are written, and the list of frames still owed.
    int             m_phase;
    int             m_row_pos;
    int             m_frames[$];
    bit             m_overrun;
    logic [FPC-1:0] m_far;
    int             m_done;
    bit             m_err;
    int             m_lfs_left;
    logic [4:0]     last_rowsel;

    task automatic model_reset();
        m_phase    = P_HUNT;
        m_row_pos  = 0;
        m_frames.delete();
        m_overrun  = 1'b0;
        m_far      = '0;
        m_done     = 0;
        m_err      = 1'b0;
        m_lfs_left = 0;
    endtask

    function automatic logic [4:0] exp_rowsel(bit ws);
        if (ws && m_phase == P_DATA) return 5'(NR - m_row_pos);
        return 5'h1f;
    endfunction

    task automatic model_step(bit ws, logic [31:0] wd);
        int idx;
        int burst;
        int f;
        if (m_lfs_left > 0) m_lfs_left--;
        if (!ws) return;
        case (m_phase)
            P_HUNT: begin
                if (wd == SYNC) begin
                    m_phase = P_HDR;
                    m_err   = 1'b0;
                end
            end
            P_HDR: begin
                idx   = int'(wd[4:0]);
                burst = int'(wd[30:24]);
                if (wd[31]) begin
                    m_phase = P_HUNT;
                end else if (idx >= FPC) begin
                    m_err   = 1'b1;
                    m_phase = P_HUNT;
                end else begin
                    m_frames.delete();
                    for (int k = idx; k <= idx + burst && k < FPC; k++) m_frames.push_back(k);
                    m_overrun = (idx + burst >= FPC);
                    m_row_pos = 0;
                    m_phase   = P_DATA;
                end
            end
            default: begin
                m_row_pos++;
                if (m_row_pos == NR) begin
                    f          = m_frames.pop_front();
                    m_far      = '0;
                    m_far[f]   = 1'b1;
                    m_done     = (m_done + 1) % 65536;
                    m_lfs_left = SL;
                    m_row_pos  = 0;
                    if (m_frames.size() == 0) begin
                        if (m_overrun) begin
                            m_err   = 1'b1;
                            m_phase = P_HUNT;
                        end else begin
                            m_phase = P_HDR;
                        end
                    end
                end
            end
        endcase
    endtask

    // One clock: drive a word, check RowSelect mid-cycle, then check all
    // registered outputs just after the edge against the model.
    task automatic cycle(bit ws, logic [31:0] wd);
        logic [4:0] ers;
        WriteStrobe = ws;
        WriteData   = wd;
        @(negedge CLK);
        ers = exp_rowsel(ws);
        last_rowsel = RowSelect;
        checks++;
        if (RowSelect !== ers) begin
            errors++;
            $display("FAIL rowsel: got %0h expected %0h", RowSelect, ers);
        end
        @(posedge CLK);
        #1;
        model_step(ws, wd);
        checks++;
        if (FrameAddressRegister !== m_far) begin
            errors++;
            $display("FAIL frame_addr: got %0h expected %0h", FrameAddressRegister, m_far);
        end
        checks++;
        if (LongFrameStrobe !== (m_lfs_left > 0)) begin
            errors++;
            $display("FAIL strobe: got %0b expected %0b", LongFrameStrobe, (m_lfs_left > 0));
        end
        checks++;
        if (FramesDone !== 16'(m_done)) begin
            errors++;
            $display("FAIL frames_done: got %0d expected %0d", FramesDone, m_done);
        end
        checks++;
        if (Error !== m_err) begin
            errors++;
            $display("FAIL error: got %0b expected %0b", Error, m_err);
        end
        checks++;
        if (Synced !== (m_phase != P_HUNT)) begin
            errors++;
            $display("FAIL synced: got %0b expected %0b", Synced, (m_phase != P_HUNT));
        end
        checks++;
        if (Busy !== (m_phase == P_DATA)) begin
            errors++;
            $display("FAIL busy: got %0b expected %0b", Busy, (m_phase == P_DATA));
        end
    endtask

    task automatic test_reset();
        model_reset();
        Resetn = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({FrameAddressRegister, LongFrameStrobe, FramesDone, Error, Synced, Busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {FrameAddressRegister, LongFrameStrobe, FramesDone, Error, Synced, Busy});
        end
        checks++;
        if (RowSelect !== 5'h1f) begin
            errors++;
            $display("FAIL reset_rowsel: got %0h expected 1f", RowSelect);
        end
        Resetn = 1'b1;
        repeat (3) cycle(1'b0, $urandom);
    endtask

    task automatic test_single_frame();
        cycle(1'b1, 32'h1234_5678);
        cycle(1'b1, SYNC);
        cycle(1'b1, 32'h0000_0003);
        for (int i = 0; i < NR; i++) begin
            cycle(1'b1, $urandom);
            checks++;
            if (last_rowsel !== 5'(NR - i)) begin
                errors++;
                $display("FAIL single_row_seq: got %0d expected %0d", last_rowsel, NR - i);
            end
        end
        checks++;
        if (FrameAddressRegister !== 20'h0_0008 || FramesDone !== 16'd1 || Busy !== 1'b0
            || LongFrameStrobe !== 1'b1) begin
            errors++;
            $display("FAIL single_commit: got far=%0h done=%0d busy=%0b lfs=%0b expected far=8 done=1 busy=0 lfs=1",
                     FrameAddressRegister, FramesDone, Busy, LongFrameStrobe);
        end
        cycle(1'b0, 32'h0);
        checks++;
        if (LongFrameStrobe !== 1'b1) begin
            errors++;
            $display("FAIL single_strobe_2nd: got %0b expected 1", LongFrameStrobe);
        end
        cycle(1'b0, 32'h0);
        checks++;
        if (LongFrameStrobe !== 1'b0 || FrameAddressRegister !== 20'h0_0008) begin
            errors++;
            $display("FAIL single_strobe_drop: got lfs=%0b far=%0h expected lfs=0 far=8",
                     LongFrameStrobe, FrameAddressRegister);
        end
    endtask

    task automatic test_burst_stalls();
        int start;
        start = m_done;
        cycle(1'b1, 32'h0200_0005);
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < NR; r++) begin
                repeat ($urandom_range(0, 2)) cycle(1'b0, $urandom);
                cycle(1'b1, $urandom);
            end
            checks++;
            if (FrameAddressRegister !== (20'h1 << (5 + k))) begin
                errors++;
                $display("FAIL burst_commit_%0d: got %0h expected %0h", k,
                         FrameAddressRegister, 20'h1 << (5 + k));
            end
        end
        checks++;
        if (FramesDone !== 16'(start + 3) || Busy !== 1'b0 || Synced !== 1'b1) begin
            errors++;
            $display("FAIL burst_end: got done=%0d busy=%0b synced=%0b expected done=%0d busy=0 synced=1",
                     FramesDone, Busy, Synced, start + 3);
        end
    endtask

    task automatic test_overrun();
        cycle(1'b1, 32'h0300_0012);
        repeat (NR) cycle(1'b1, $urandom);
        checks++;
        if (FrameAddressRegister !== 20'h4_0000 || Error !== 1'b0) begin
            errors++;
            $display("FAIL overrun_f18: got far=%0h err=%0b expected far=40000 err=0",
                     FrameAddressRegister, Error);
        end
        repeat (NR) cycle(1'b1, $urandom);
        checks++;
        if (FrameAddressRegister !== 20'h8_0000 || Error !== 1'b1 || Synced !== 1'b0) begin
            errors++;
            $display("FAIL overrun_f19: got far=%0h err=%0b synced=%0b expected far=80000 err=1 synced=0",
                     FrameAddressRegister, Error, Synced);
        end
        cycle(1'b1, SYNC);
        checks++;
        if (Error !== 1'b0 || Synced !== 1'b1) begin
            errors++;
            $display("FAIL overrun_resync: got err=%0b synced=%0b expected err=0 synced=1", Error, Synced);
        end
    endtask

    task automatic test_bad_header_desync();
        cycle(1'b1, 32'h0000_0019);
        checks++;
        if (Error !== 1'b1 || Synced !== 1'b0) begin
            errors++;
            $display("FAIL bad_index: got err=%0b synced=%0b expected err=1 synced=0", Error, Synced);
        end
        cycle(1'b1, SYNC);
        cycle(1'b1, 32'h8000_0000);
        checks++;
        if (Error !== 1'b0 || Synced !== 1'b0 || LongFrameStrobe !== 1'b0) begin
            errors++;
            $display("FAIL desync: got err=%0b synced=%0b lfs=%0b expected 0 0 0",
                     Error, Synced, LongFrameStrobe);
        end
    endtask

    task automatic assert_reset_now(int rows);
        #2;
        Resetn = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({FrameAddressRegister, LongFrameStrobe, FramesDone, Error, Synced, Busy} !== '0
            || RowSelect !== 5'h1f) begin
            errors++;
            $display("FAIL midframe_reset_%0d: got %0h rs=%0h expected 0 rs=1f", rows,
                     {FrameAddressRegister, LongFrameStrobe, FramesDone, Error, Synced, Busy}, RowSelect);
        end
        WriteStrobe = 1'b0;
        @(posedge CLK);
        #1;
        Resetn = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        cycle(1'b1, SYNC);
        cycle(1'b1, 32'h0100_0002);
        repeat (NR + 1) cycle(1'b1, $urandom);
        assert_reset_now(NR + 1);
        cycle(1'b1, SYNC);
        cycle(1'b1, 32'h0000_0004);
        repeat (7) cycle(1'b1, $urandom);
        assert_reset_now(7);
        repeat (4) cycle(1'b1, $urandom);
        checks++;
        if (Synced !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_ignore: got synced=%0b expected 0", Synced);
        end
        cycle(1'b1, SYNC);
        cycle(1'b1, 32'h0000_0001);
        repeat (NR) cycle(1'b1, $urandom);
        checks++;
        if (FrameAddressRegister !== 20'h0_0002 || FramesDone !== 16'd1) begin
            errors++;
            $display("FAIL post_reset_frame: got far=%0h done=%0d expected far=2 done=1",
                     FrameAddressRegister, FramesDone);
        end
    endtask

    task automatic test_random();
        bit          ws;
        logic [31:0] w;
        for (int n = 0; n < 1500; n++) begin
            ws = ($urandom_range(0, 3) != 0);
            w  = $urandom;
            if (m_phase == P_HUNT && $urandom_range(0, 1) == 1) begin
                w = SYNC;
            end else if (m_phase == P_HDR) begin
                w = {($urandom_range(0, 7) == 0), 7'($urandom_range(0, 3)), 19'($urandom), 5'($urandom)};
            end
            cycle(ws, w);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_frame();
        test_burst_stalls();
        test_overrun();
        test_bad_header_desync();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/config_frame_loader.md
# config_frame_loader

Parametrised successor to the fabric configuration frame FSM. It sits between the configuration word source (UART or parallel port) and the fabric frame data/strobe network. It hunts for a sync word, then decodes frame headers carrying a binary frame index and a burst count, and sequences row selects for each data word. Each completed frame drives a one-hot frame strobe of configurable length, with auto-increment across multi-frame bursts, and error/status reporting.

## Interface
Parameters:
- NumberOfRows, 16, data words (rows) per frame; must be < 2^RowSelectWidth − 1
- RowSelectWidth, 5, width of RowSelect
- FramesPerColumn, 20, number of frames; width of the one-hot FrameAddressRegister
- FrameSelWidth, 5, width of the header frame-index field; ≤ 24
- SyncWord, 32'hFAB0_FAB1, pattern that enters the synced state
- DesyncBit, 31, header bit that returns the block to unsynced
- StrobeLength, 2, LongFrameStrobe high time in cycles; 1 ≤ StrobeLength ≤ NumberOfRows

Ports:
- CLK  in  1  clock, all logic on posedge
- Resetn  in  1  asynchronous active-low reset
- WriteData  in  32  configuration word
- WriteStrobe  in  1  WriteData valid this cycle
- FrameAddressRegister  out  FramesPerColumn  one-hot address of the frame being strobed
- LongFrameStrobe  out  1  frame commit strobe
- RowSelect  out  RowSelectWidth  row receiving WriteData; all ones = none
- Synced  out  1  state ≠ UNSYNC
- Busy  out  1  state = DATA
- Error  out  1  sticky header/burst error
- FramesDone  out  16  count of committed frames, wraps

## Operation
- All registered outputs reset to 0, and state resets to UNSYNC. RowSelect is combinational; it is all ones while reset is held and WriteStrobe=0.
- Header layout:
  - bit DesyncBit = desync
  - [30:24] = BurstCnt (frames − 1)
  - [FrameSelWidth−1:0] = frame index
  - other bits ignored
- UNSYNC: on WriteStrobe with WriteData==SyncWord, go to HEADER and clear Error. All other words are ignored.
- HEADER, on WriteStrobe:
  - DesyncBit=1: go to UNSYNC.
  - Frame index ≥ FramesPerColumn: set Error, go to UNSYNC.
  - Otherwise: load CurFrame=index, Remaining=BurstCnt, RowCnt=NumberOfRows, go to DATA.
- DATA, on WriteStrobe:
  - RowSelect = RowCnt. Rows are written NumberOfRows down to 1.
  - RowCnt decrements.
  - When RowCnt==1 (last row), commit:
    - FrameAddressRegister ← onehot(CurFrame)
    - LongFrameStrobe asserts
    - FramesDone increments
    - If Remaining==0: go to HEADER.
    - Else if CurFrame+1 ≥ FramesPerColumn: commit still happens, then set Error and go to UNSYNC.
    - Else: CurFrame+1, Remaining−1, RowCnt reload, stay in DATA.
- RowSelect = RowCnt only when state=DATA and WriteStrobe=1; otherwise all ones. Sync and header words never select a row.
- WriteStrobe=0 stalls every state indefinitely, with no timeout.
- FrameAddressRegister holds its value until the next commit.
- A new commit while LongFrameStrobe is still high reloads its counter to StrobeLength. The configured parameter constraint prevents this.

## Timing
- Commit edge = the posedge that accepts the last-row word.
- FrameAddressRegister and LongFrameStrobe update on the commit edge. LongFrameStrobe stays high exactly StrobeLength cycles, then drops regardless of WriteStrobe.
- The next word (header or burst row 1) is accepted on the very next cycle, so there is no dead cycle between frames.
- Error and FramesDone update on the commit or header edge that causes them. Error clears on the edge that accepts SyncWord.
- Resetn assertion mid-frame clears everything immediately, including an in-progress LongFrameStrobe. Deassertion is sampled synchronously; the first accepted word is the one on the first posedge after release.
- Synced and Busy are registered decodes of state with zero added latency.

## Test plan
- Reset and idle: Resetn low, then release with WriteStrobe=0 → all outputs 0, RowSelect all ones, Synced=0.
- Single frame: 32'h12345678, then SyncWord, header 32'h0000_0003, then 16 data words → RowSelect 16..1; on the 16th edge FrameAddressRegister=1<<3, LongFrameStrobe high 2 cycles, FramesDone=1, Busy=0.
- Burst with stalls: header 32'h0200_0005, 48 data words with random WriteStrobe gaps → commits of 1<<5, 1<<6, 1<<7, FramesDone=3, then return to HEADER.
- Burst overrun: header 32'h0300_0012 with FramesPerColumn=20 → frames 18 and 19 commit; on the 19 commit Error=1 and Synced=0; the next SyncWord clears Error.
- Bad header and desync: header index 25 → Error=1, UNSYNC. Header 32'h8000_0000 after sync → UNSYNC, Error=0, no strobe.
- Reset mid-frame: Resetn low after 7 rows → state UNSYNC; after release, data words are ignored until SyncWord.
